// File: rtl/modn_pwm_stage.sv
// modn_pwm_stage
// Turns the count bus of a free-running mod-N counter into a PWM waveform.
// The duty setting is double-buffered and only takes effect when a period
// starts. A small FSM starts and stops the output on period boundaries, so
// no period is ever cut short. Each completed active period produces a
// one-cycle tick and increments a saturating period counter.

module modn_pwm_stage #(
    parameter  int N  = 10,
    parameter  int PW = 16,
    localparam int CW = (N > 1) ? $clog2(N) : 1,
    localparam int DW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] count_in,
    input  logic          en,
    input  logic          duty_load,
    input  logic [DW-1:0] duty_in,
    output logic          pwm_out,
    output logic          period_tick,
    output logic          running,
    output logic [PW-1:0] periods_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [DW-1:0] DUTY_MAX   = DW'(N);
    localparam logic [CW-1:0] COUNT_LAST = CW'(N - 1);

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] duty_pending;
    logic [DW-1:0] duty_active;

    logic [DW-1:0] duty_clamped;
    logic [DW-1:0] duty_pending_next;
    logic [DW-1:0] duty_active_next;
    logic          period_start;
    logic          period_end;
    logic          compare_hit;

    logic          pwm_next;
    logic          tick_next;
    logic          done_inc;

    // Decode period boundaries and derive the duty value that applies to the
    // count sampled on this edge.
    always_comb begin
        period_start = (count_in == '0);
        period_end   = (count_in == COUNT_LAST);

        // Anything above N means "always high", so clamp to N.
        duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;

        duty_pending_next = duty_load ? duty_clamped : duty_pending;

        // At a period start the active duty is reloaded. A load on that same
        // edge bypasses the pending register so it applies to this period.
        duty_active_next = period_start ? duty_pending_next : duty_active;

        // duty_active_next equals duty_active except at a period start, so it
        // is also the value to compare against on this edge.
        compare_hit = (DW'(count_in) < duty_active_next);
    end

    // Hold the pending duty (from the last load) and the active duty (locked
    // for the current period).
    always_ff @(posedge clk) begin
        // NOTE: every sequential register uses non-blocking assignments, so
        // all flops update from the same pre-edge values.
        if (rst) begin
            duty_pending <= '0;
            duty_active  <= '0;
        end else begin
            duty_pending <= duty_pending_next;
            duty_active  <= duty_active_next;
        end
    end

    // Compute the next run/stop state and the values the output registers
    // take on this edge.
    always_comb begin
        // NOTE: assign every output a default before the case statement so
        // that no path infers a latch.
        state_next = state;
        pwm_next   = 1'b0;
        tick_next  = 1'b0;
        done_inc   = 1'b0;

        unique case (state)
            IDLE: begin
                if (en) begin
                    state_next = ARMED;
                end
            end

            ARMED: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (period_start) begin
                    // Enter RUN on the boundary edge itself; the first
                    // compare is issued now.
                    state_next = RUN;
                    pwm_next   = compare_hit;
                end
            end

            RUN: begin
                pwm_next = compare_hit;
                if (period_end) begin
                    tick_next = 1'b1;
                    done_inc  = 1'b1;
                end
                // A drop at the period end drains the whole following period.
                if (!en) begin
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                pwm_next = compare_hit;
                if (period_end) begin
                    tick_next = 1'b1;
                    done_inc  = 1'b1;
                end
                if (en) begin
                    state_next = RUN;
                end else if (period_end) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. A reset stops the output immediately, with no drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Register the PWM output, the end-of-period tick and the saturating
    // count of completed periods.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out      <= 1'b0;
            period_tick  <= 1'b0;
            periods_done <= '0;
        end else begin
            pwm_out     <= pwm_next;
            period_tick <= tick_next;
            if (done_inc && (periods_done != '1)) begin
                periods_done <= periods_done + PW'(1);
            end
        end
    end

    // Decode running from the registered state, so no input reaches it
    // combinationally.
    assign running = (state == RUN) || (state == DRAIN);

endmodule
